axi_read_arbiter: RTL
=====================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDRESS_WIDTH, 8, AXI read address width.
- DATA_WIDTH, 32, AXI read data width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning; N is 0 or 1, one set per requester):
- aclk, input, 1, single clock; all state changes on its rising edge.
- aresetn, input, 1, asynchronous active-low reset.
- sN_araddr/sN_arlen/sN_arsize/sN_arburst, input, ADDRESS_WIDTH/8/3/2, AR payload from requester N.
- sN_arvalid, input, 1, requester N address valid.
- sN_arready, output, 1, request N accepted.
- sN_rdata/sN_rresp/sN_rlast, output, DATA_WIDTH/2/1, R payload to requester N.
- sN_rvalid, output, 1, read beat valid to requester N.
- sN_rready, input, 1, requester N ready for a beat.
- m_araddr/m_arlen/m_arsize/m_arburst, output, ADDRESS_WIDTH/8/3/2, AR payload to the shared axi_slave_ram.
- m_arvalid, output, 1, shared-slave address valid.
- m_arready, input, 1, shared-slave address ready.
- m_rdata/m_rresp/m_rlast, input, DATA_WIDTH/2/1, R payload from the shared slave.
- m_rvalid, input, 1, shared-slave beat valid.
- m_rready, output, 1, shared-slave beat ready.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ADDR and DATA.
REQ-004 IDLE: when any sN_arvalid=1, the winner's sN_arready SHALL be 1 combinationally in that cycle (the loser's 0); at the rising edge the winner's AR payload and index SHALL be latched and the FSM SHALL go to ADDR.
REQ-005 IDLE with no sN_arvalid: both sN_arready SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-006 ADDR: m_arvalid SHALL be 1 and m_ar* SHALL be the latched payload, held stable until m_arvalid&&m_arready; on that edge the FSM SHALL go to DATA.
REQ-007 Outside ADDR, m_arvalid SHALL be 0; sN_arready SHALL be 0 outside IDLE.
REQ-008 DATA: m_rready SHALL equal the owner's sN_rready; the owner's sN_rvalid SHALL equal m_rvalid; the non-owner's sN_rvalid SHALL be 0.
REQ-009 sN_rdata/sN_rresp/sN_rlast SHALL equal m_rdata/m_rresp/m_rlast for both requesters, with no added latency.
REQ-010 DATA: on m_rvalid&&m_rready&&m_rlast the FSM SHALL go to IDLE and last_grant SHALL be set to the owner index; arlen+1 beats SHALL be forwarded per burst.
REQ-011 Outside DATA, m_rready and both sN_rvalid SHALL be 0.
REQ-012 A requester SHALL be granted at most one burst per arbitration; a new request SHALL be arbitrated no earlier than the cycle after the rlast handshake (one IDLE cycle minimum between bursts).
REQ-013 A requester deasserting sN_arvalid while not granted SHALL lose nothing; no request SHALL be queued internally.

Reset
REQ-014 On aresetn=0 the FSM SHALL enter IDLE immediately and asynchronously, with last_grant=1, latched payload=0 and owner=0.
REQ-015 While aresetn=0, all outputs SHALL be 0 (sN_arready, m_arvalid, m_rready, sN_rvalid, m_ar*).
REQ-016 Reset asserted in ADDR or DATA SHALL abort the burst with no further beat forwarded; after release the FSM SHALL start in IDLE.

Configuration
REQ-017 With AXI_ARB_RR_EN defined, a simultaneous request SHALL be granted to the requester other than last_grant (round-robin).
REQ-018 Without AXI_ARB_RR_EN, s0 SHALL always win a simultaneous request (fixed priority), and last_grant SHALL be maintained but unused.

Verification
REQ-019 Reset, then s0 only requests araddr=0x10, arlen=4 -> s0_arready pulses 1 cycle; m_araddr=0x10, m_arlen=4; 5 beats on s0 only, s0_rlast on the 5th; s1_rvalid stays 0.
REQ-020 Both request in the same cycle after reset, with AXI_ARB_RR_EN -> s0 served first, then s1; repeating both -> s0 again, strictly alternating.
REQ-021 Same stimulus without AXI_ARB_RR_EN -> s0 granted every time while s0_arvalid stays high; s1 waits.
REQ-022 Owner s1 drops s1_rready for 3 cycles mid-burst (arlen=2) -> m_rready=0 for those cycles, no beat lost, 3 beats total.
REQ-023 m_arready held 0 for 4 cycles in ADDR -> m_arvalid and m_araddr stay stable; the FSM enters DATA on the 5th cycle.
REQ-024 aresetn=0 during beat 2 of arlen=4 -> all outputs 0 immediately; after release a fresh s1 request (arlen=0) completes with 1 beat.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read slave between two requesters.
// Build option AXI_ARB_RR_EN selects round-robin; default is s0 fixed priority.
module axi_read_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [ADDRESS_WIDTH-1:0] s0_araddr,
    input  logic [7:0]               s0_arlen,
    input  logic [2:0]               s0_arsize,
    input  logic [1:0]               s0_arburst,
    input  logic                     s0_arvalid,
    output logic                     s0_arready,
    output logic [DATA_WIDTH-1:0]    s0_rdata,
    output logic [1:0]               s0_rresp,
    output logic                     s0_rlast,
    output logic                     s0_rvalid,
    input  logic                     s0_rready,
    input  logic [ADDRESS_WIDTH-1:0] s1_araddr,
    input  logic [7:0]               s1_arlen,
    input  logic [2:0]               s1_arsize,
    input  logic [1:0]               s1_arburst,
    input  logic                     s1_arvalid,
    output logic                     s1_arready,
    output logic [DATA_WIDTH-1:0]    s1_rdata,
    output logic [1:0]               s1_rresp,
    output logic                     s1_rlast,
    output logic                     s1_rvalid,
    input  logic                     s1_rready,
    output logic [ADDRESS_WIDTH-1:0] m_araddr,
    output logic [7:0]               m_arlen,
    output logic [2:0]               m_arsize,
    output logic [1:0]               m_arburst,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    input  logic [DATA_WIDTH-1:0]    m_rdata,
    input  logic [1:0]               m_rresp,
    input  logic                     m_rlast,
    input  logic                     m_rvalid,
    output logic                     m_rready
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_e;

    state_e                   state_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [7:0]               len_q;
    logic [2:0]               size_q;
    logic [1:0]               burst_q;
    logic                     owner_q;
    logic                     last_grant_q;
    logic                     gnt0;
    logic                     gnt1;

`ifndef AXI_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    // Pick the winner among pending requests while idle and out of reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (aresetn && state_q == IDLE) begin
            if (s0_arvalid && s1_arvalid) begin
`ifdef AXI_ARB_RR_EN
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = s0_arvalid;
                gnt1 = s1_arvalid;
            end
        end
    end

    // Arbitration FSM: latch the grant, issue AR, then forward the burst.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        state_q <= ADDR;
                        owner_q <= gnt1;
                        addr_q  <= gnt1 ? s1_araddr : s0_araddr;
                        len_q   <= gnt1 ? s1_arlen : s0_arlen;
                        size_q  <= gnt1 ? s1_arsize : s0_arsize;
                        burst_q <= gnt1 ? s1_arburst : s0_arburst;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (m_rvalid && m_rready && m_rlast) begin
                        state_q      <= IDLE;
                        last_grant_q <= owner_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s0_arready = gnt0;
    assign s1_arready = gnt1;

    assign m_arvalid = (state_q == ADDR);
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arsize  = size_q;
    assign m_arburst = burst_q;

    assign m_rready  = (state_q == DATA) &&
                       (owner_q ? s1_rready : s0_rready);
    assign s0_rvalid = (state_q == DATA) && !owner_q && m_rvalid;
    assign s1_rvalid = (state_q == DATA) && owner_q && m_rvalid;

    assign s0_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s0_rlast = m_rlast;
    assign s1_rdata = m_rdata;
    assign s1_rresp = m_rresp;
    assign s1_rlast = m_rlast;

endmodule
